// File: rtl/trap_sequencer_if.sv
// Decode/CSR/PC handshake bundle for the trap sequencer.
// The master side drives decode outcomes and CSR state, and the slave side drives the strobes.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            inst_invalid;
  logic            exc_request;
  logic [XLEN-1:0] exc_cause;
  logic            exc_ret;
  logic            is_wfi;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [2:0]      irq_pending;
  logic [2:0]      irq_enable;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mepc_we;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_we;
  logic [XLEN-1:0] mcause_wdata;
  logic            mstatus_we;
  logic            mstatus_mie_next;
  logic            mstatus_mpie_next;
  logic            sleeping;

  modport master (
    output instr_valid, inst_invalid, exc_request, exc_cause,
    output exc_ret, is_wfi, instr_pc, mtvec, mepc,
    output mstatus_mie, mstatus_mpie, irq_pending, irq_enable,
    input  stall, flush, redirect_valid, redirect_pc,
    input  mepc_we, mepc_wdata, mcause_we, mcause_wdata,
    input  mstatus_we, mstatus_mie_next, mstatus_mpie_next,
    input  sleeping
  );

  modport slave (
    input  instr_valid, inst_invalid, exc_request, exc_cause,
    input  exc_ret, is_wfi, instr_pc, mtvec, mepc,
    input  mstatus_mie, mstatus_mpie, irq_pending, irq_enable,
    output stall, flush, redirect_valid, redirect_pc,
    output mepc_we, mepc_wdata, mcause_we, mcause_wdata,
    output mstatus_we, mstatus_mie_next, mstatus_mpie_next,
    output sleeping
  );
endinterface

// File: rtl/trap_sequencer.sv
// Multicycle M-mode trap controller: sequences mepc/mcause/mstatus
// updates and the PC redirect for traps, MRET and WFI sleep.
module trap_sequencer (
  input  logic      clk,
  input  logic      rst_n,
  trap_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SAVE    = 3'd1;
  localparam logic [2:0] RESTORE = 3'd2;
  localparam logic [2:0] JUMP    = 3'd3;
  localparam logic [2:0] SLEEP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] wfi_pc_q, wfi_pc_d;

  logic [2:0]  irq_m;
  logic        irq_any;
  logic        irq_take;
  logic [3:0]  irq_code;
  logic [31:0] irq_cause;
  logic [31:0] tvec_base;
  logic [31:0] irq_tgt;
  logic        det;
  logic        exc_any;
  logic        trap_det;
  logic        mret_det;
  logic        wfi_det;
  logic [1:0]  unused_mepc_lo;

  assign unused_mepc_lo = bus.mepc[1:0];

  assign irq_m     = bus.irq_pending & bus.irq_enable;
  assign irq_any   = |irq_m;
  assign irq_take  = bus.mstatus_mie & irq_any;
  assign irq_cause = {1'b1, 27'd0, irq_code};
  assign tvec_base = {bus.mtvec[31:2], 2'b00};
  assign irq_tgt   = (bus.mtvec[1:0] == 2'b01)
                   ? tvec_base + {26'd0, irq_code, 2'b00}
                   : tvec_base;

  // Fixed interrupt priority: MEI, then MSI, then MTI.
  always_comb begin
    irq_code = 4'd0;
    priority case (1'b1)
      irq_m[2]: irq_code = 4'd11;
      irq_m[0]: irq_code = 4'd3;
      irq_m[1]: irq_code = 4'd7;
      default:  irq_code = 4'd0;
    endcase
  end

  assign det      = rst_n & (state_q == IDLE) & bus.instr_valid;
  assign exc_any  = irq_take | bus.inst_invalid | bus.exc_request;
  assign trap_det = det & exc_any;
  assign mret_det = det & ~exc_any & bus.exc_ret;
  assign wfi_det  = det & ~exc_any & ~bus.exc_ret & bus.is_wfi;

  // Next-state and capture logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    mepc_d   = mepc_q;
    cause_d  = cause_q;
    tgt_d    = tgt_q;
    wfi_pc_d = wfi_pc_q;
    case (state_q)
      IDLE: begin
        if (trap_det) begin
          mepc_d  = bus.instr_pc;
          state_d = SAVE;
          if (irq_take) begin
            cause_d = irq_cause;
            tgt_d   = irq_tgt;
          end else if (bus.inst_invalid) begin
            cause_d = 32'd2;
            tgt_d   = tvec_base;
          end else begin
            cause_d = bus.exc_cause;
            tgt_d   = tvec_base;
          end
        end else if (mret_det) begin
          tgt_d   = {bus.mepc[31:2], 2'b00};
          state_d = RESTORE;
        end else if (wfi_det) begin
          wfi_pc_d = bus.instr_pc + 32'd4;
          state_d  = SLEEP;
        end
      end
      SAVE:    state_d = JUMP;
      RESTORE: state_d = JUMP;
      JUMP:    state_d = IDLE;
      SLEEP: begin
        if (irq_any) begin
          if (bus.mstatus_mie) begin
            mepc_d  = wfi_pc_q;
            cause_d = irq_cause;
            tgt_d   = irq_tgt;
            state_d = SAVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured trap context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      cause_q  <= '0;
      tgt_q    <= '0;
      wfi_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      cause_q  <= cause_d;
      tgt_q    <= tgt_d;
      wfi_pc_q <= wfi_pc_d;
    end
  end

  assign bus.stall = (state_q != IDLE) | trap_det | mret_det | wfi_det;
  assign bus.flush = trap_det | mret_det;

  assign bus.mepc_we      = (state_q == SAVE);
  assign bus.mepc_wdata   = bus.mepc_we ? mepc_q : 32'd0;
  assign bus.mcause_we    = (state_q == SAVE);
  assign bus.mcause_wdata = bus.mcause_we ? cause_q : 32'd0;

  assign bus.mstatus_we        = (state_q == SAVE) | (state_q == RESTORE);
  assign bus.mstatus_mie_next  = (state_q == RESTORE) & bus.mstatus_mpie;
  assign bus.mstatus_mpie_next = ((state_q == SAVE) & bus.mstatus_mie)
                               | (state_q == RESTORE);

  assign bus.redirect_valid = (state_q == JUMP);
  assign bus.redirect_pc    = bus.redirect_valid ? tgt_q : 32'd0;
  assign bus.sleeping       = (state_q == SLEEP);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: traps, vectored irqs,
// priority, MRET, WFI sleep/wake and async reset mid-sequence.
module tb_trap_sequencer;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  trap_sequencer_if bus ();

  trap_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drop_instr();
    bus.instr_valid  = 1'b0;
    bus.inst_invalid = 1'b0;
    bus.exc_request  = 1'b0;
    bus.exc_ret      = 1'b0;
    bus.is_wfi       = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".stall"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, ".flush"}, {31'd0, bus.flush}, 32'd0);
    chk({tag, ".rv"}, {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, ".rpc"}, bus.redirect_pc, 32'd0);
    chk({tag, ".mepc_we"}, {31'd0, bus.mepc_we}, 32'd0);
    chk({tag, ".mcause_we"}, {31'd0, bus.mcause_we}, 32'd0);
    chk({tag, ".mstatus_we"}, {31'd0, bus.mstatus_we}, 32'd0);
    chk({tag, ".sleeping"}, {31'd0, bus.sleeping}, 32'd0);
  endtask

  // Instruction already presented; checks T, T+1, T+2, T+3.
  task automatic trap_flow(input string tag, input logic [31:0] epc,
                           input logic [31:0] cause,
                           input logic [31:0] tgt);
    #1;
    chk({tag, ".flushT"}, {31'd0, bus.flush}, 32'd1);
    chk({tag, ".stallT"}, {31'd0, bus.stall}, 32'd1);
    tick();
    drop_instr();
    bus.irq_pending = 3'b000;
    #1;
    chk({tag, ".mepc_we"}, {31'd0, bus.mepc_we}, 32'd1);
    chk({tag, ".mepc"}, bus.mepc_wdata, epc);
    chk({tag, ".mcause_we"}, {31'd0, bus.mcause_we}, 32'd1);
    chk({tag, ".mcause"}, bus.mcause_wdata, cause);
    chk({tag, ".mstatus_we"}, {31'd0, bus.mstatus_we}, 32'd1);
    chk({tag, ".mie_next"}, {31'd0, bus.mstatus_mie_next}, 32'd0);
    chk({tag, ".mpie_next"}, {31'd0, bus.mstatus_mpie_next}, 32'd1);
    chk({tag, ".flush1"}, {31'd0, bus.flush}, 32'd0);
    chk({tag, ".stall1"}, {31'd0, bus.stall}, 32'd1);
    tick();
    chk({tag, ".rv"}, {31'd0, bus.redirect_valid}, 32'd1);
    chk({tag, ".rpc"}, bus.redirect_pc, tgt);
    chk({tag, ".we2"}, {31'd0, bus.mepc_we}, 32'd0);
    tick();
    chk({tag, ".rv3"}, {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, ".stall3"}, {31'd0, bus.stall}, 32'd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    drop_instr();
    bus.exc_cause    = 32'd0;
    bus.instr_pc     = 32'd0;
    bus.mtvec        = 32'd0;
    bus.mepc         = 32'd0;
    bus.mstatus_mie  = 1'b0;
    bus.mstatus_mpie = 1'b0;
    bus.irq_pending  = 3'b000;
    bus.irq_enable   = 3'b000;

    repeat (2) tick();
    all_zero("reset");
    rst_n = 1'b1;
    tick();
    all_zero("idle");

    // ECALL, non-vectored
    bus.mtvec       = 32'h0000_0200;
    bus.mstatus_mie = 1'b1;
    bus.instr_pc    = 32'h0000_0100;
    bus.exc_cause   = 32'd11;
    bus.exc_request = 1'b1;
    bus.instr_valid = 1'b1;
    trap_flow("ecall", 32'h100, 32'h0000_000B, 32'h200);

    // Vectored interrupt, MEI beats MTI
    bus.mtvec       = 32'h0000_0401;
    bus.irq_enable  = 3'b111;
    bus.irq_pending = 3'b110;
    bus.instr_pc    = 32'h0000_0080;
    bus.instr_valid = 1'b1;
    trap_flow("irq_mei", 32'h80, 32'h8000_000B, 32'h42C);

    bus.irq_pending = 3'b010;
    bus.instr_valid = 1'b1;
    trap_flow("irq_mti", 32'h80, 32'h8000_0007, 32'h41C);

    // Interrupt with no valid instruction is ignored
    bus.irq_pending = 3'b001;
    #1;
    chk("irq_novalid.stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("irq_novalid.we", {31'd0, bus.mepc_we}, 32'd0);

    // MIE=0: pending irq does not trap
    bus.mstatus_mie = 1'b0;
    bus.instr_valid = 1'b1;
    #1;
    chk("irq_mie0.stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("irq_mie0.we", {31'd0, bus.mepc_we}, 32'd0);
    drop_instr();
    bus.irq_pending = 3'b000;
    bus.mstatus_mie = 1'b1;

    // Illegal beats ECALL; exceptions never vectored
    bus.instr_pc     = 32'h0000_0500;
    bus.inst_invalid = 1'b1;
    bus.exc_request  = 1'b1;
    bus.instr_valid  = 1'b1;
    trap_flow("illegal", 32'h500, 32'h0000_0002, 32'h400);

    // Interrupt beats illegal
    bus.inst_invalid = 1'b1;
    bus.exc_request  = 1'b1;
    bus.irq_pending  = 3'b001;
    bus.instr_valid  = 1'b1;
    trap_flow("irq_wins", 32'h500, 32'h8000_0003, 32'h40C);

    // MRET
    bus.mepc         = 32'h0000_0123;
    bus.mstatus_mie  = 1'b0;
    bus.mstatus_mpie = 1'b1;
    bus.exc_ret      = 1'b1;
    bus.instr_valid  = 1'b1;
    #1;
    chk("mret.flushT", {31'd0, bus.flush}, 32'd1);
    chk("mret.stallT", {31'd0, bus.stall}, 32'd1);
    tick();
    drop_instr();
    #1;
    chk("mret.mstatus_we", {31'd0, bus.mstatus_we}, 32'd1);
    chk("mret.mie_next", {31'd0, bus.mstatus_mie_next}, 32'd1);
    chk("mret.mpie_next", {31'd0, bus.mstatus_mpie_next}, 32'd1);
    chk("mret.mepc_we", {31'd0, bus.mepc_we}, 32'd0);
    tick();
    chk("mret.rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("mret.rpc", bus.redirect_pc, 32'h120);
    tick();
    chk("mret.rv3", {31'd0, bus.redirect_valid}, 32'd0);

    // WFI with MIE=0: wake returns to IDLE, no redirect
    bus.mtvec       = 32'h0000_0200;
    bus.instr_pc    = 32'h0000_0300;
    bus.is_wfi      = 1'b1;
    bus.instr_valid = 1'b1;
    bus.irq_enable  = 3'b010;
    #1;
    chk("wfi0.stallT", {31'd0, bus.stall}, 32'd1);
    chk("wfi0.flushT", {31'd0, bus.flush}, 32'd0);
    tick();
    drop_instr();
    chk("wfi0.sleep", {31'd0, bus.sleeping}, 32'd1);
    bus.irq_pending = 3'b001;
    tick();
    chk("wfi0.sleep_masked", {31'd0, bus.sleeping}, 32'd1);
    chk("wfi0.stall_sleep", {31'd0, bus.stall}, 32'd1);
    bus.irq_enable = 3'b001;
    tick();
    chk("wfi0.woke", {31'd0, bus.sleeping}, 32'd0);
    chk("wfi0.stall_idle", {31'd0, bus.stall}, 32'd0);
    chk("wfi0.rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("wfi0.we", {31'd0, bus.mepc_we}, 32'd0);
    tick();
    chk("wfi0.rv2", {31'd0, bus.redirect_valid}, 32'd0);
    bus.irq_pending = 3'b000;

    // WFI with MIE=1: wake traps with mepc = pc+4
    bus.mstatus_mie = 1'b1;
    bus.is_wfi      = 1'b1;
    bus.instr_valid = 1'b1;
    tick();
    drop_instr();
    chk("wfi1.sleep", {31'd0, bus.sleeping}, 32'd1);
    bus.irq_pending = 3'b001;
    tick();
    bus.irq_pending = 3'b000;
    #1;
    chk("wfi1.mepc_we", {31'd0, bus.mepc_we}, 32'd1);
    chk("wfi1.mepc", bus.mepc_wdata, 32'h304);
    chk("wfi1.mcause", bus.mcause_wdata, 32'h8000_0003);
    chk("wfi1.mie_next", {31'd0, bus.mstatus_mie_next}, 32'd0);
    chk("wfi1.mpie_next", {31'd0, bus.mstatus_mpie_next}, 32'd1);
    tick();
    chk("wfi1.rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("wfi1.rpc", bus.redirect_pc, 32'h200);
    tick();

    // Async reset while in SAVE
    bus.instr_pc    = 32'h0000_0100;
    bus.exc_cause   = 32'd3;
    bus.exc_request = 1'b1;
    bus.instr_valid = 1'b1;
    tick();
    drop_instr();
    chk("rst.in_save", {31'd0, bus.mepc_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    all_zero("rst.save");
    chk("rst.mepc_wdata", bus.mepc_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    all_zero("rst.after1");
    tick();
    all_zero("rst.after2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
